// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan sequencer.
// Contents: FSM state enum, default word/address width, default mux inversion.
package mux_scan_pkg;

  localparam int unsigned WidthDflt  = 16;
  localparam int unsigned AwDflt     = 4;
  localparam bit          InvertDflt = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bundle between the scan sequencer and its environment (host request side and
// the 16:1 registered mux it exercises).
//   enable, start, word_in   : host -> sequencer control and word to scan
//   busy, done, word_out,
//   err_mask, err            : sequencer -> host status and result
//   mux_data, mux_addr       : sequencer -> mux data and select
//   mux_out                  : mux -> sequencer registered output bit
// master: environment side (host + mux). slave: the sequencer.
interface mux_scan_ctrl_if
  import mux_scan_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDflt,
  parameter int unsigned AW    = AwDflt
) ();

  logic             enable;
  logic             start;
  logic [WIDTH-1:0] word_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] word_out;
  logic [WIDTH-1:0] err_mask;
  logic             err;
  logic [WIDTH-1:0] mux_data;
  logic [AW-1:0]    mux_addr;
  logic             mux_out;

  modport master (
    output enable, start, word_in, mux_out,
    input  busy, done, word_out, err_mask, err, mux_data, mux_addr
  );

  modport slave (
    input  enable, start, word_in, mux_out,
    output busy, done, word_out, err_mask, err, mux_data, mux_addr
  );

endinterface

// File: rtl/mux_scan_collect.sv
// Bit collector for the scan sequencer: an enable-gated register that either
// clears or writes one bit at a given index per enabled cycle.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   enable       : clock enable; low holds the register
//   clear        : zero the whole word (wins over wr)
//   wr, idx, bit_in : write bit_in at position idx
//   word_next    : value the register takes on the next enabled edge, so the
//                  caller can capture the final word on the same edge as the
//                  last bit lands
module mux_scan_collect #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             wr,
  input  logic [AW-1:0]    idx,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_next
);

  logic [WIDTH-1:0] word_q;

  always_comb begin
    word_next = word_q;
    if (clear) begin
      word_next = '0;
    end else if (wr) begin
      word_next[idx] = bit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
    end else if (enable) begin
      word_q <= word_next;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer and collector for a registered, optionally inverting WIDTH:1
// bit mux. On an accepted start it latches word_in onto the mux data bus, walks
// the mux address 0..WIDTH-1, collects the registered mux output (one cycle
// behind the address), un-inverts it and reports the rebuilt word, a per-bit
// mismatch mask and a one-cycle done pulse.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, wins over everything
//   bus   : slave side of mux_scan_ctrl_if (host control/status + mux wiring)
// All outputs are registered; mux_out only reaches outputs through flops.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned WIDTH  = WidthDflt,
  parameter int unsigned AW     = AwDflt,
  parameter bit          INVERT = InvertDflt
) (
  input logic            clk,
  input logic            reset,
  mux_scan_ctrl_if.slave bus
);

  localparam logic [AW-1:0] LastAddr = AW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic             err_q, err_d;

  logic             coll_clear;
  logic             coll_wr;
  logic [AW-1:0]    coll_idx;
  logic [WIDTH-1:0] coll_next;

  mux_scan_collect #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_collect (
    .clk       (clk),
    .reset     (reset),
    .enable    (bus.enable),
    .clear     (coll_clear),
    .wr        (coll_wr),
    .idx       (coll_idx),
    .bit_in    (bus.mux_out),
    .word_next (coll_next)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    word_out_d = word_out_q;
    err_mask_d = err_mask_q;
    err_d      = err_q;
    coll_clear = 1'b0;
    coll_wr    = 1'b0;
    // The mux register delays its output by one cycle, so the bit arriving
    // now belongs to the address presented in the previous cycle.
    coll_idx   = addr_q - AW'(1);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StScan;
          data_d     = bus.word_in;
          addr_d     = '0;
          busy_d     = 1'b1;
          coll_clear = 1'b1;
        end
      end
      StScan: begin
        // Nothing valid arrives during the first scan cycle (addr 0).
        coll_wr = (addr_q != '0);
        if (addr_q == LastAddr) begin
          state_d = StDrain;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      StDrain: begin
        // Last bit lands this edge; capture the result from the collector's
        // next value so done and word_out appear together.
        coll_wr    = 1'b1;
        coll_idx   = LastAddr;
        state_d    = StDone;
        done_d     = 1'b1;
        word_out_d = coll_next ^ {WIDTH{INVERT}};
        err_mask_d = word_out_d ^ data_q;
        err_d      = |err_mask_d;
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      word_out_q <= '0;
      err_mask_q <= '0;
      err_q      <= 1'b0;
    end else if (bus.enable) begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      word_out_q <= word_out_d;
      err_mask_q <= err_mask_d;
      err_q      <= err_d;
    end
  end

  assign bus.mux_data = data_q;
  assign bus.mux_addr = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.word_out = word_out_q;
  assign bus.err_mask = err_mask_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: drives directed scenarios then random traffic, with
// a transaction-level model (count of enabled cycles since accept) checked
// against every DUT output on every falling edge.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned A   = 4;
  localparam bit          INV = 1'b1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_scan_ctrl_if #(.WIDTH(W), .AW(A)) bus ();

  mux_scan_ctrl #(
    .WIDTH  (W),
    .AW     (A),
    .INVERT (INV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit chk_on      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered inverting mux; shares the clock enable, optional stuck bit.
  bit stuck_en   = 1'b0;
  int stuck_addr = 0;
  bit stuck_val  = 1'b0;
  always @(posedge clk) begin
    if (reset) bus.mux_out <= 1'b0;
    else if (bus.enable)
      bus.mux_out <= (stuck_en && int'(bus.mux_addr) == stuck_addr) ? stuck_val
                                                               : (bus.mux_data[bus.mux_addr] ^ INV);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // What the mux would have returned for each bit, re-inverted.
  function automatic logic [W-1:0] recon(input logic [W-1:0] d);
    logic [W-1:0] r;
    logic         mo;
    for (int k = 0; k < int'(W); k++) begin
      mo   = (stuck_en && k == stuck_addr) ? stuck_val : (d[k] ^ INV);
      r[k] = mo ^ INV;
    end
    return r;
  endfunction

  // Model: m_n counts enabled cycles since the accepting edge (1 = first
  // cycle after accept); done is the cycle with m_n == W+2.
  bit           m_active    = 1'b0;
  int           m_n         = 0;
  int           m_idle_addr = 0;
  logic [W-1:0] m_data      = '0;
  logic [W-1:0] m_wout      = '0;
  logic [W-1:0] m_emask     = '0;
  int           exp_addr;

  always @(negedge clk) begin
    if (chk_on) begin
      exp_addr = m_active ? ((m_n - 1 > int'(W) - 1) ? int'(W) - 1 : m_n - 1) : m_idle_addr;
      check("busy", 32'(bus.busy), 32'(m_active));
      check("done", 32'(bus.done), 32'(m_active && m_n == int'(W) + 2));
      check("mux_addr", 32'(bus.mux_addr), 32'(exp_addr));
      check("mux_data", 32'(bus.mux_data), 32'(m_data));
      check("word_out", 32'(bus.word_out), 32'(m_wout));
      check("err_mask", 32'(bus.err_mask), 32'(m_emask));
      check("err", 32'(bus.err), 32'(|m_emask));
    end
    // Advance the model across the coming rising edge.
    if (reset) begin
      m_active = 1'b0; m_n = 0; m_idle_addr = 0;
      m_data = '0; m_wout = '0; m_emask = '0;
    end else if (bus.enable) begin
      if (!m_active) begin
        if (bus.start) begin
          m_active = 1'b1; m_n = 1; m_data = bus.word_in;
        end
      end else if (m_n == int'(W) + 2) begin
        m_active = 1'b0; m_idle_addr = int'(W) - 1;
      end else begin
        m_n++;
        if (m_n == int'(W) + 2) begin
          m_wout  = recon(m_data);
          m_emask = m_wout ^ m_data;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_scan(input logic [W-1:0] w, output int t);
    bus.word_in = w;
    bus.start   = 1'b1;
    t           = cyc;
    tick();
    bus.start   = 1'b0;
  endtask

  // Returns at the falling edge of the done cycle; at = -1 on timeout.
  task automatic wait_done(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", max, cyc);
    end
  endtask

  int t, d, d1, d2;

  initial begin
    bus.enable  = 1'b0;
    bus.start   = 1'b0;
    bus.word_in = '0;
    reset       = 1'b1;
    repeat (2) tick();
    reset      = 1'b0;
    bus.enable = 1'b1;
    chk_on     = 1'b1;

    // Reset state.
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_addr", 32'(bus.mux_addr), 32'h0);
    check("rst_word", 32'(bus.word_out), 32'h0);

    // 1: plain scan, address walk and latency.
    start_scan(16'hA5C3, t);
    for (int k = 0; k < 16; k++) begin
      check("s1_addr_seq", 32'(bus.mux_addr), 32'(k));
      if (k < 15) tick();
    end
    wait_done(10, d);
    check("s1_latency", 32'(d - t), 32'd18);
    check("s1_word", 32'(bus.word_out), 32'hA5C3);
    check("s1_mask", 32'(bus.err_mask), 32'h0);
    check("s1_err", 32'(bus.err), 32'h0);
    tick();

    // 2: enable low for cycles T+5..T+9.
    start_scan(16'hA5C3, t);
    repeat (4) tick();
    bus.enable = 1'b0;
    repeat (5) tick();
    bus.enable = 1'b1;
    wait_done(30, d);
    check("s2_latency", 32'(d - t), 32'd23);
    check("s2_word", 32'(bus.word_out), 32'hA5C3);
    check("s2_err", 32'(bus.err), 32'h0);
    tick();

    // 3: start while busy is ignored.
    start_scan(16'hA5C3, t);
    repeat (5) tick();
    bus.word_in = 16'h1234;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    wait_done(30, d);
    check("s3_latency", 32'(d - t), 32'd18);
    check("s3_word", 32'(bus.word_out), 32'hA5C3);
    tick();

    // 4: mux bit 7 stuck at output 1.
    stuck_en = 1'b1; stuck_addr = 7; stuck_val = 1'b1;
    start_scan(16'h0080, t);
    wait_done(30, d);
    check("s4_word", 32'(bus.word_out), 32'h0000);
    check("s4_mask", 32'(bus.err_mask), 32'h0080);
    check("s4_err", 32'(bus.err), 32'h1);
    tick();
    stuck_en = 1'b0;

    // 5: reset mid-scan, then a fresh scan.
    start_scan(16'hA5C3, t);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s5_busy", 32'(bus.busy), 32'h0);
    check("s5_done", 32'(bus.done), 32'h0);
    check("s5_mask", 32'(bus.err_mask), 32'h0);
    check("s5_data", 32'(bus.mux_data), 32'h0);
    check("s5_addr", 32'(bus.mux_addr), 32'h0);
    for (int i = 0; i < 20; i++) begin
      check("s5_no_done", 32'(bus.done), 32'h0);
      tick();
    end
    start_scan(16'hFFFF, t);
    wait_done(30, d);
    check("s5_latency", 32'(d - t), 32'd18);
    check("s5_word", 32'(bus.word_out), 32'hFFFF);
    check("s5_err", 32'(bus.err), 32'h0);
    tick();

    // 6: start held high, back-to-back scans.
    bus.word_in = 16'h0000;
    bus.start   = 1'b1;
    t           = cyc;
    tick();
    bus.word_in = 16'hFFFF;
    wait_done(30, d1);
    check("s6_latency", 32'(d1 - t), 32'd18);
    check("s6_word1", 32'(bus.word_out), 32'h0000);
    tick();
    wait_done(30, d2);
    check("s6_spacing", 32'(d2 - d1), 32'd19);
    check("s6_word2", 32'(bus.word_out), 32'hFFFF);
    tick();
    bus.start = 1'b0;
    repeat (20) tick();

    // Random traffic, a fresh mux fault configuration per block.
    for (int blk = 0; blk < 4; blk++) begin
      reset      = 1'b1;
      stuck_en   = 1'($urandom_range(0, 1));
      stuck_addr = int'($urandom_range(0, 15));
      stuck_val  = 1'($urandom_range(0, 1));
      tick();
      reset = 1'b0;
      for (int i = 0; i < 600; i++) begin
        bus.enable  = ($urandom_range(0, 9) != 0);
        bus.start   = ($urandom_range(0, 3) == 0);
        bus.word_in = 16'($urandom);
        reset       = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
